// File: rtl/zeta_stream_gen.sv
// Zeta-factor streamer for Kyber/ML-KEM NTT, inverse NTT and base-case multiply.
// Emits NUM_LANES twiddles per valid/ready beat, tagged with layer and end-of-layer markers.

package poly_arith_pkg;
    localparam int unsigned ZETA_BITS = 12;
    typedef logic [ZETA_BITS-1:0] zeta_t;

    // 17^brv7(i) mod 3329
    localparam zeta_t ZETA_NTT_TABLE [128] = '{
        12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
        12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
        12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
        12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
        12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
        12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
        12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
        12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
        12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
        12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
        12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
        12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
        12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
        12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
        12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
        12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
    };

    // 17^(2*brv7(i)+1) mod 3329
    localparam zeta_t ZETA_MUL_TABLE [128] = '{
        12'd17,   12'd3312, 12'd2761, 12'd568,  12'd583,  12'd2746, 12'd2649, 12'd680,
        12'd1637, 12'd1692, 12'd723,  12'd2606, 12'd2288, 12'd1041, 12'd1100, 12'd2229,
        12'd1409, 12'd1920, 12'd2662, 12'd667,  12'd3281, 12'd48,   12'd233,  12'd3096,
        12'd756,  12'd2573, 12'd2156, 12'd1173, 12'd3015, 12'd314,  12'd3050, 12'd279,
        12'd1703, 12'd1626, 12'd1651, 12'd1678, 12'd2789, 12'd540,  12'd1789, 12'd1540,
        12'd1847, 12'd1482, 12'd952,  12'd2377, 12'd1461, 12'd1868, 12'd2687, 12'd642,
        12'd939,  12'd2390, 12'd2308, 12'd1021, 12'd2437, 12'd892,  12'd2388, 12'd941,
        12'd733,  12'd2596, 12'd2337, 12'd992,  12'd268,  12'd3061, 12'd641,  12'd2688,
        12'd1584, 12'd1745, 12'd2298, 12'd1031, 12'd2037, 12'd1292, 12'd3220, 12'd109,
        12'd375,  12'd2954, 12'd2549, 12'd780,  12'd2090, 12'd1239, 12'd1645, 12'd1684,
        12'd1063, 12'd2266, 12'd319,  12'd3010, 12'd2773, 12'd556,  12'd757,  12'd2572,
        12'd2099, 12'd1230, 12'd561,  12'd2768, 12'd2466, 12'd863,  12'd2594, 12'd735,
        12'd2804, 12'd525,  12'd1092, 12'd2237, 12'd403,  12'd2926, 12'd1026, 12'd2303,
        12'd1143, 12'd2186, 12'd2150, 12'd1179, 12'd2775, 12'd554,  12'd886,  12'd2443,
        12'd1722, 12'd1607, 12'd1212, 12'd2117, 12'd1874, 12'd1455, 12'd1029, 12'd2300,
        12'd2110, 12'd1219, 12'd2935, 12'd394,  12'd885,  12'd2444, 12'd2154, 12'd1175
    };
endpackage

module zeta_stream_gen
    import poly_arith_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned ZW        = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode,
    output logic                      zeta_valid,
    input  logic                      zeta_ready,
    output logic [NUM_LANES*ZW-1:0]   zeta_data,
    output logic [2:0]                zeta_layer,
    output logic                      zeta_layer_last,
    output logic                      zeta_last,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned BEATS = 128 / NUM_LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [2:0]                layer_q, layer_d;
    logic                      valid_q, valid_d;
    logic [NUM_LANES*ZW-1:0]   data_q, data_d;
    logic                      layer_last_q, layer_last_d;
    logic                      last_q, last_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      load;

    // Table lookup for every lane of one beat; b is the butterfly index within the layer.
    function automatic logic [NUM_LANES*ZW-1:0] lanes_f(input logic [1:0]    m,
                                                        input logic [2:0]    l,
                                                        input logic [BW-1:0] bt);
        logic [NUM_LANES*ZW-1:0] d;
        logic [7:0]              b;
        logic [6:0]              idx;
        d = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            b = 8'(bt) * 8'(NUM_LANES) + 8'(j);
            case (m)
                2'd0:    idx = 7'((8'd1 << l) + (b >> (3'd7 - l)));
                2'd1:    idx = 7'((8'd1 << (3'd7 - l)) - 8'd1 - (b >> (l + 3'd1)));
                default: idx = 7'(b);
            endcase
            if (m == 2'd2) d[ZW*j +: ZW] = ZW'(ZETA_MUL_TABLE[idx]);
            else           d[ZW*j +: ZW] = ZW'(ZETA_NTT_TABLE[idx]);
        end
        return d;
    endfunction

    // Next-state, counters and next registered outputs
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        beat_d       = beat_q;
        layer_d      = layer_q;
        valid_d      = valid_q;
        data_d       = data_q;
        layer_last_d = layer_last_q;
        last_d       = last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (mode != 2'd3)) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    beat_d  = '0;
                    layer_d = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                if (valid_q && zeta_ready) begin
                    if (last_q) begin
                        state_d      = S_DONE;
                        valid_d      = 1'b0;
                        layer_last_d = 1'b0;
                        last_d       = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (layer_last_q) begin
                            beat_d  = '0;
                            layer_d = layer_q + 3'd1;
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Present the beat selected by the updated counters
        if (load) begin
            data_d       = lanes_f(mode_d, layer_d, beat_d);
            layer_last_d = (beat_d == BW'(BEATS - 1));
            last_d       = layer_last_d && (layer_d == ((mode_d == 2'd2) ? 3'd0 : 3'd6));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            beat_q       <= '0;
            layer_q      <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            layer_last_q <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            beat_q       <= beat_d;
            layer_q      <= layer_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            layer_last_q <= layer_last_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign zeta_valid      = valid_q;
    assign zeta_data       = data_q;
    assign zeta_layer      = layer_q;
    assign zeta_layer_last = layer_last_q;
    assign zeta_last       = last_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_zeta_stream_gen.sv
// Bench for zeta_stream_gen: expected zetas are recomputed as powers of 17 mod 3329
// and compared beat by beat under random backpressure, reset abort and start abuse.

module tb_zeta_stream_gen;

    localparam int unsigned ZW  = 12;
    localparam int          BPL = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, ready;
    logic [1:0]        mode;
    logic              a_valid, a_ll, a_last, a_busy, a_done;
    logic [2*ZW-1:0]   a_data;
    logic [2:0]        a_layer;

    logic              b_start, b_ready;
    logic [1:0]        b_mode;
    logic              b_valid, b_ll, b_last, b_busy, b_done;
    logic [4*ZW-1:0]   b_data;
    logic [2:0]        b_layer;

    int n_checks   = 0;
    int n_errors   = 0;
    int a_done_cnt = 0;
    int acc0[$], acc1[$], accl[$], accll[$], acclast[$];

    zeta_stream_gen #(.NUM_LANES(2), .ZW(ZW)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .zeta_valid(a_valid), .zeta_ready(ready), .zeta_data(a_data),
        .zeta_layer(a_layer), .zeta_layer_last(a_ll), .zeta_last(a_last),
        .busy(a_busy), .done(a_done)
    );

    zeta_stream_gen #(.NUM_LANES(4), .ZW(ZW)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode),
        .zeta_valid(b_valid), .zeta_ready(b_ready), .zeta_data(b_data),
        .zeta_layer(b_layer), .zeta_layer_last(b_ll), .zeta_last(b_last),
        .busy(b_busy), .done(b_done)
    );

    always @(posedge clk) if (a_done) a_done_cnt <= a_done_cnt + 1;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int brv7(input int i);
        int r = 0;
        for (int k = 0; k < 7; k++) if (i[k]) r |= (1 << (6 - k));
        return r;
    endfunction

    function automatic int pow17(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * 17) % 3329;
        return r;
    endfunction

    // Zeta for mode m, layer l, butterfly b, straight from the index rules
    function automatic int exp_lane(input int m, input int l, input int b);
        int idx;
        if (m == 0) begin
            idx = (1 << l) + (b >> (7 - l));
            return pow17(brv7(idx));
        end else if (m == 1) begin
            idx = (1 << (7 - l)) - 1 - (b >> (l + 1));
            return pow17(brv7(idx));
        end
        return pow17(2 * brv7(b) + 1);
    endfunction

    task automatic run_a(input logic [1:0] m, input int rdy_pct, input int abort_at, input bit poke);
        int nb, k, cyc, dc0;
        logic [2*ZW-1:0] pd;
        logic [2:0]      pl;
        logic            pll, plast;
        bit              stalled;
        nb = (m == 2'd2) ? BPL : 7 * BPL;
        k = 0; cyc = 0; stalled = 1'b0;
        pd = '0; pl = '0; pll = 1'b0; plast = 1'b0;
        acc0.delete(); acc1.delete(); accl.delete(); accll.delete(); acclast.delete();
        dc0 = a_done_cnt;
        start = 1'b1; mode = m;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_rise", a_busy, 1);
        while (k < nb) begin
            if (k == abort_at) begin
                ready = 1'b0; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (cyc > 4000) begin
                check_eq("cycle_budget_beats", k, nb);
                return;
            end
            if (!a_valid) begin
                check_eq("valid_in_run", a_valid, 1);
                return;
            end
            if (stalled) begin
                check_eq("hold_data", int'(a_data == pd), 1);
                check_eq("hold_flags", int'({a_layer, a_ll, a_last} == {pl, pll, plast}), 1);
            end
            for (int j = 0; j < 2; j++)
                check_eq("lane", int'(a_data[ZW*j +: ZW]), exp_lane(int'(m), k / BPL, (k % BPL) * 2 + j));
            check_eq("layer", a_layer, k / BPL);
            check_eq("layer_last", a_ll, int'(k % BPL == BPL - 1));
            check_eq("last", a_last, int'(k == nb - 1));
            ready = ($urandom_range(99) < rdy_pct);
            if (poke) begin
                start = 1'($urandom_range(1));
                mode  = 2'($urandom_range(3));
            end
            if (ready) begin
                acc0.push_back(int'(a_data[ZW-1:0]));
                acc1.push_back(int'(a_data[2*ZW-1:ZW]));
                accl.push_back(int'(a_layer));
                accll.push_back(int'(a_ll));
                acclast.push_back(int'(a_last));
                k++;
            end
            stalled = !ready;
            pd = a_data; pl = a_layer; pll = a_ll; plast = a_last;
            @(negedge clk);
            cyc++;
        end
        check_eq("done_pulse", a_done, 1);
        check_eq("valid_in_done", a_valid, 0);
        check_eq("busy_in_done", a_busy, 1);
        start = poke; mode = m;
        @(negedge clk);
        start = 1'b0;
        check_eq("done_one_cycle", a_done, 0);
        check_eq("busy_after_done", a_busy, 0);
        check_eq("valid_after_done", a_valid, 0);
        check_eq("done_count", a_done_cnt - dc0, 1);
    endtask

    task automatic spot_mode0();
        int nll, nlast;
        nll = 0; nlast = 0;
        if (acc0.size() != 448) begin
            check_eq("m0_beats", acc0.size(), 448);
            return;
        end
        check_eq("m0_b0_l0", acc0[0], 1729);    check_eq("m0_b0_l1", acc1[0], 1729);
        check_eq("m0_b64_l0", acc0[64], 2580);  check_eq("m0_b64_l1", acc1[64], 2580);
        check_eq("m0_b96_l0", acc0[96], 3289);  check_eq("m0_b96_l1", acc1[96], 3289);
        check_eq("m0_b447_l0", acc0[447], 2154); check_eq("m0_b447_l1", acc1[447], 2154);
        check_eq("m0_b447_last", acclast[447], 1);
        for (int k = 0; k < 448; k++) begin
            if (accll[k] != 0) begin
                nll++;
                check_eq("m0_ll_pos", k % 64, 63);
            end
            nlast += acclast[k];
        end
        check_eq("m0_ll_count", nll, 7);
        check_eq("m0_last_count", nlast, 1);
    endtask

    task automatic run_b();
        b_start = 1'b1; b_mode = 2'd2;
        @(negedge clk);
        b_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (!b_valid) begin
                check_eq("b_valid", b_valid, 1);
                return;
            end
            for (int j = 0; j < 4; j++)
                check_eq("b_lane", int'(b_data[ZW*j +: ZW]), exp_lane(2, 0, k * 4 + j));
            check_eq("b_layer", b_layer, 0);
            check_eq("b_last", b_last, int'(k == 31));
            if (k == 0) begin
                check_eq("b0_l0", int'(b_data[11:0]), 17);    check_eq("b0_l1", int'(b_data[23:12]), 3312);
                check_eq("b0_l2", int'(b_data[35:24]), 2761); check_eq("b0_l3", int'(b_data[47:36]), 568);
            end
            if (k == 31) begin
                check_eq("b31_l0", int'(b_data[11:0]), 885);   check_eq("b31_l1", int'(b_data[23:12]), 2444);
                check_eq("b31_l2", int'(b_data[35:24]), 2154); check_eq("b31_l3", int'(b_data[47:36]), 1175);
                check_eq("b31_ll", b_ll, 1);
            end
            @(negedge clk);
        end
        check_eq("b_done", b_done, 1);
        check_eq("b_valid_done", b_valid, 0);
    endtask

    initial begin
        int dc_abort;
        rst = 1'b1; start = 1'b0; mode = 2'd0; ready = 1'b0;
        b_start = 1'b0; b_mode = 2'd0; b_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", a_valid, 0);
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_done", a_done, 0);
        check_eq("rst_flags", int'({a_ll, a_last}), 0);
        check_eq("rst_layer", a_layer, 0);
        check_eq("rst_data", int'(a_data), 0);
        check_eq("rst_b_any", int'(b_valid | b_busy | (b_data != '0)), 0);
        rst = 1'b0;
        @(negedge clk);

        run_a(2'd0, 100, -1, 1'b0);
        spot_mode0();

        run_a(2'd1, 100, -1, 1'b0);
        if (acc0.size() == 448) begin
            check_eq("m1_b0", acc0[0], 2154);    check_eq("m1_b0_layer", accl[0], 0);
            check_eq("m1_b447", acc1[447], 1729); check_eq("m1_b447_layer", accl[447], 6);
            check_eq("m1_b447_last", acclast[447], 1);
        end else begin
            check_eq("m1_beats", acc0.size(), 448);
        end

        run_a(2'd0, 55, -1, 1'b0);
        spot_mode0();

        dc_abort = a_done_cnt;
        run_a(2'd0, 100, 100, 1'b0);
        check_eq("abort_valid", a_valid, 0);
        check_eq("abort_busy", a_busy, 0);
        check_eq("abort_data", int'(a_data), 0);
        check_eq("abort_flags", int'({a_layer, a_ll, a_last, a_done}), 0);

        rst = 1'b1; start = 1'b1; mode = 2'd0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_eq("rst_over_start", a_busy, 0);

        start = 1'b1; mode = 2'd3;
        @(negedge clk);
        start = 1'b0;
        check_eq("mode3_busy", a_busy, 0);
        check_eq("mode3_valid", a_valid, 0);
        @(negedge clk);
        check_eq("mode3_busy_later", a_busy, 0);
        check_eq("abort_no_done", a_done_cnt - dc_abort, 0);

        run_a(2'd2, 100, -1, 1'b0);
        run_a(2'd0, 70, -1, 1'b1);
        spot_mode0();

        run_b();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/zeta_stream_gen.md
ZETA_STREAM_GEN -- requirements
Module: zeta_stream_gen

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2, meaning zetas emitted per beat; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have parameter ZW, default 12, meaning the zeta width in bits.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, a request to begin a sequence.
REQ-006 SHALL have port mode, input, 2 bits, sampled with start: 0 = forward NTT, 1 = inverse NTT, 2 = MultiplyNTTs, 3 = reserved.
REQ-007 SHALL have port zeta_valid, output, 1 bit, meaning the beat is valid.
REQ-008 SHALL have port zeta_ready, input, 1 bit, the consumer accept signal.
REQ-009 SHALL have port zeta_data, output, NUM_LANES*ZW bits; lane j occupies bits [ZW*j+ZW-1 : ZW*j].
REQ-010 SHALL have port zeta_layer, output, 3 bits, the layer index of the current beat (0 in mode 2).
REQ-011 SHALL have port zeta_layer_last, output, 1 bit, marking the final beat of a layer.
REQ-012 SHALL have port zeta_last, output, 1 bit, marking the final beat of the sequence.
REQ-013 SHALL have port busy, output, 1 bit, high while not IDLE.
REQ-014 SHALL have port done, output, 1 bit, a one-cycle pulse after the last beat is accepted.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; DONE lasts exactly one cycle with done=1.
REQ-016 SHALL leave IDLE on start=1 with mode in 0..2; start with mode=3 SHALL be ignored; start while busy SHALL be ignored.
REQ-017 SHALL assert zeta_valid for the first beat on the cycle after start is accepted; busy SHALL rise in the same cycle.
REQ-018 SHALL complete a beat when zeta_valid && zeta_ready; while zeta_valid && !zeta_ready, zeta_data, zeta_layer, zeta_layer_last and zeta_last SHALL hold stable.
REQ-019 SHALL sustain one beat per cycle while zeta_ready=1, using registered outputs and no bubbles.
REQ-020 Butterfly index within a layer: b = (beat_in_layer * NUM_LANES) + j, for lane j.
REQ-021 Mode 0 SHALL produce 7 layers L=0..6, each 128/NUM_LANES beats, with lane value ZETA_NTT_TABLE[2^L + (b >> (7-L))].
REQ-022 Mode 1 SHALL produce 7 layers L=0..6, each 128/NUM_LANES beats, with lane value ZETA_NTT_TABLE[2^(7-L) - 1 - (b >> (L+1))].
REQ-023 Mode 2 SHALL produce 1 layer of 128/NUM_LANES beats, with lane value ZETA_MUL_TABLE[b].
REQ-024 SHALL source table contents from poly_arith_pkg; values SHALL be zero-extended to ZW when ZW>12.
REQ-025 SHALL assert zeta_layer_last on the final beat of each layer.
REQ-026 SHALL assert zeta_last on the final beat only, coincident with zeta_layer_last.
REQ-027 SHALL use a beat counter that wraps within a layer, with the layer counter incrementing at layer_last acceptance; no counter SHALL exceed its range.
REQ-028 SHALL enter DONE on acceptance of the zeta_last beat, deassert zeta_valid in the same edge, and return to IDLE next cycle.
REQ-029 SHALL ignore a start issued in DONE; start SHALL be accepted again from IDLE.

Reset
REQ-030 On rst=1 the state SHALL be IDLE, and zeta_valid, zeta_layer_last, zeta_last, busy, done, zeta_layer and zeta_data SHALL all be 0.
REQ-031 rst SHALL override start; reset mid-sequence SHALL abort immediately, with no done pulse, and the next start SHALL begin from beat 0.

Verification
REQ-032 Mode 0, NUM_LANES=2, ready=1 -> 448 beats; beat 0 = {1729,1729}; beat 64 = {2580,2580}; beat 96 = {3289,3289}; beat 447 = {2154,2154} with zeta_last=1; layer_last on beats 63, 127, ..., 447; done on the cycle after beat 447.
REQ-033 Mode 1, NUM_LANES=2 -> beat 0 = {2154,2154} at layer 0; beat 447 = {1729,1729} at layer 6, zeta_last=1.
REQ-034 Mode 2, NUM_LANES=4 -> 32 beats; beat 0 lanes 0..3 = 17, 3312, 2761, 568; beat 31 = 885, 2444, 2154, 1175 with zeta_last=1 and zeta_layer=0.
REQ-035 Random zeta_ready backpressure, mode 0 -> outputs stable while stalled; the accepted sequence is identical to REQ-032 and has no drops or duplicates.
REQ-036 Reset at beat 100 of mode 0, then start with mode=3, then start with mode=2 -> all outputs 0 after reset; mode=3 ignored (busy stays 0); mode 2 sequence starts at beat 0.
REQ-037 start pulsed during RUN and during DONE -> ignored; exactly one sequence and one done pulse produced.
